// File: rtl/cache_mem_arbiter.sv
// rtl/cache_mem_arbiter.sv - shares one line-wide memory port between I-cache and D-cache
// Fixed D-over-I priority by default; define ARB_ROUND_ROBIN_EN to alternate grants on ties.
module cache_mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int LINE_W = 256
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              i_enable_i,
    input  logic [ADDR_W-1:0] i_addr_i,
    output logic [LINE_W-1:0] i_data_o,
    output logic              i_ack_o,
    input  logic              d_enable_i,
    input  logic              d_write_i,
    input  logic [ADDR_W-1:0] d_addr_i,
    input  logic [LINE_W-1:0] d_data_i,
    output logic [LINE_W-1:0] d_data_o,
    output logic              d_ack_o,
    output logic              mem_enable_o,
    output logic              mem_write_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [LINE_W-1:0] mem_data_o,
    input  logic [LINE_W-1:0] mem_data_i,
    input  logic              mem_ack_i
);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    state_t              state_q;
    logic                owner_q;
    logic                i_ack_q, d_ack_q;
    logic [LINE_W-1:0]   i_data_q, d_data_q;
    logic                mem_enable_q, mem_write_q;
    logic [ADDR_W-1:0]   mem_addr_q;
    logic [LINE_W-1:0]   mem_data_q;
    logic                pick_d;

`ifdef ARB_ROUND_ROBIN_EN
    logic                last_grant_q;

    // On a tie the side that was not served last wins; last_grant_q=1 means D.
    always_comb begin
        pick_d = d_enable_i;
        if (i_enable_i && d_enable_i) begin
            pick_d = ~last_grant_q;
        end
    end
`else
    always_comb begin
        pick_d = d_enable_i;
    end
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= S_IDLE;
            owner_q      <= 1'b0;
            i_ack_q      <= 1'b0;
            d_ack_q      <= 1'b0;
            i_data_q     <= '0;
            d_data_q     <= '0;
            mem_enable_q <= 1'b0;
            mem_write_q  <= 1'b0;
            mem_addr_q   <= '0;
            mem_data_q   <= '0;
`ifdef ARB_ROUND_ROBIN_EN
            last_grant_q <= 1'b0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    i_ack_q <= 1'b0;
                    d_ack_q <= 1'b0;
                    if (i_enable_i || d_enable_i) begin
                        owner_q      <= pick_d;
                        mem_addr_q   <= pick_d ? d_addr_i : i_addr_i;
                        mem_write_q  <= pick_d & d_write_i;
                        mem_data_q   <= pick_d ? d_data_i : '0;
                        mem_enable_q <= 1'b1;
                        state_q      <= S_BUSY;
                    end else begin
                        mem_enable_q <= 1'b0;
                    end
                end
                S_BUSY: begin
                    // Payload stays frozen; requester inputs are not looked at until completion.
                    if (mem_ack_i) begin
                        mem_enable_q <= 1'b0;
                        mem_write_q  <= 1'b0;
                        if (owner_q) begin
                            d_data_q <= mem_data_i;
                            d_ack_q  <= 1'b1;
                        end else begin
                            i_data_q <= mem_data_i;
                            i_ack_q  <= 1'b1;
                        end
`ifdef ARB_ROUND_ROBIN_EN
                        last_grant_q <= owner_q;
`endif
                        state_q <= S_DONE;
                    end
                end
                S_DONE: begin
                    i_ack_q <= 1'b0;
                    d_ack_q <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign i_ack_o      = i_ack_q;
    assign d_ack_o      = d_ack_q;
    assign i_data_o     = i_data_q;
    assign d_data_o     = d_data_q;
    assign mem_enable_o = mem_enable_q;
    assign mem_write_o  = mem_write_q;
    assign mem_addr_o   = mem_addr_q;
    assign mem_data_o   = mem_data_q;

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// tb/tb_cache_mem_arbiter.sv - scoreboard bench for cache_mem_arbiter
module tb_cache_mem_arbiter;
    localparam int AW = 32;
    localparam int LW = 256;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          i_enable_i, d_enable_i, d_write_i;
    logic [AW-1:0] i_addr_i, d_addr_i;
    logic [LW-1:0] d_data_i;
    logic [LW-1:0] i_data_o, d_data_o;
    logic          i_ack_o, d_ack_o;
    logic          mem_enable_o, mem_write_o;
    logic [AW-1:0] mem_addr_o;
    logic [LW-1:0] mem_data_o;
    logic [LW-1:0] mem_data_i;
    logic          mem_ack_i;
    logic          ack_auto, ack_man;

    assign mem_ack_i = ack_auto | ack_man;

    always #5 clk_i = ~clk_i;

    cache_mem_arbiter #(.ADDR_W(AW), .LINE_W(LW)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .i_enable_i(i_enable_i), .i_addr_i(i_addr_i), .i_data_o(i_data_o), .i_ack_o(i_ack_o),
        .d_enable_i(d_enable_i), .d_write_i(d_write_i), .d_addr_i(d_addr_i), .d_data_i(d_data_i),
        .d_data_o(d_data_o), .d_ack_o(d_ack_o),
        .mem_enable_o(mem_enable_o), .mem_write_o(mem_write_o), .mem_addr_o(mem_addr_o),
        .mem_data_o(mem_data_o), .mem_data_i(mem_data_i), .mem_ack_i(mem_ack_i)
    );

    typedef struct {logic [AW-1:0] addr; logic wr; logic [LW-1:0] data;} mreq_t;
    typedef struct {logic side; logic [LW-1:0] data;} ack_t;

    mreq_t         mem_exp[$];
    ack_t          ack_exp[$];
    logic [LW-1:0] rd_q[$];
    int            checks = 0;
    int            errors = 0;
    bit            resp_en = 1'b1;
    int            lat = 10;

    logic [LW-1:0] line_a5, line_1234, line_5a, line_c3;

    // Memory model: answers each request after lat cycles with the next queued line.
    initial begin
        ack_auto   = 1'b0;
        mem_data_i = '0;
        forever begin
            @(negedge clk_i);
            if (resp_en && mem_enable_o) begin
                repeat (lat - 1) @(negedge clk_i);
                mem_data_i = (rd_q.size() > 0) ? rd_q.pop_front() : '0;
                ack_auto   = 1'b1;
                @(negedge clk_i);
                ack_auto   = 1'b0;
            end
        end
    end

    // Ack monitor
    always @(negedge clk_i) begin
        ack_t e;
        if (!rst_i) begin
            if (i_ack_o && d_ack_o) begin
                checks++; errors++;
                $display("FAIL both_acks i_ack=%0b d_ack=%0b required one-hot", i_ack_o, d_ack_o);
            end
            if (i_ack_o || d_ack_o) begin
                checks++;
                if (ack_exp.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_ack i_ack=%0b d_ack=%0b required none", i_ack_o, d_ack_o);
                end else begin
                    e = ack_exp.pop_front();
                    if (e.side != d_ack_o || (d_ack_o ? d_data_o : i_data_o) !== e.data) begin
                        errors++;
                        $display("FAIL ack side got=%0b exp=%0b data got=%h exp=%h",
                                 d_ack_o, e.side, d_ack_o ? d_data_o : i_data_o, e.data);
                    end
                end
            end
        end
    end

    // Memory-request monitor: content checked on issue and every cycle it stays up.
    logic  men_prev = 1'b0;
    mreq_t cur;
    always @(negedge clk_i) begin
        if (mem_enable_o) begin
            checks++;
            if (!men_prev) begin
                if (mem_exp.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_mem_req addr=%h", mem_addr_o);
                end else begin
                    cur = mem_exp.pop_front();
                end
            end
            if ({mem_addr_o, mem_write_o, mem_data_o} !== {cur.addr, cur.wr, cur.data}) begin
                errors++;
                $display("FAIL mem_req addr got=%h exp=%h wr got=%0b exp=%0b data got=%h exp=%h",
                         mem_addr_o, cur.addr, mem_write_o, cur.wr, mem_data_o, cur.data);
            end
        end
        men_prev = mem_enable_o;
    end

    task automatic check_zero(input string name);
        checks++;
        if ({i_ack_o, d_ack_o, mem_enable_o, mem_write_o, mem_addr_o, mem_data_o, i_data_o, d_data_o} !== '0) begin
            errors++;
            $display("FAIL %s outputs not zero: acks=%0b%0b men=%0b mwr=%0b addr=%h", name,
                     i_ack_o, d_ack_o, mem_enable_o, mem_write_o, mem_addr_o);
        end
    endtask

    task automatic check_bit(input string name, input logic got, input logic exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0b exp=%0b", name, got, exp);
        end
    endtask

    task automatic wait_ack(input int maxc);
        bit seen = 1'b0;
        for (int n = 0; n < maxc && !seen; n++) begin
            @(negedge clk_i);
            seen = i_ack_o || d_ack_o;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL ack_timeout no ack within %0d cycles", maxc);
        end
    endtask

    task automatic expect_txn(input bit side, input bit wr, input logic [AW-1:0] addr,
                              input logic [LW-1:0] wdata, input logic [LW-1:0] rdata);
        mreq_t m;
        ack_t  a;
        m.addr = addr; m.wr = wr; m.data = side ? wdata : '0;
        a.side = side; a.data = rdata;
        mem_exp.push_back(m);
        ack_exp.push_back(a);
        rd_q.push_back(rdata);
    endtask

    task automatic single(input bit side, input bit wr, input logic [AW-1:0] addr,
                          input logic [LW-1:0] wdata, input logic [LW-1:0] rdata);
        expect_txn(side, wr, addr, wdata, rdata);
        if (side) begin
            d_addr_i = addr; d_write_i = wr; d_data_i = wdata; d_enable_i = 1'b1;
        end else begin
            i_addr_i = addr; i_enable_i = 1'b1;
        end
        @(negedge clk_i);
        check_bit("issue_next_cycle", mem_enable_o, 1'b1);
        wait_ack(40);
        i_enable_i = 1'b0;
        d_enable_i = 1'b0;
        repeat (2) @(negedge clk_i);
    endtask

    task automatic pulse_reset();
        rst_i = 1'b1;
        repeat (2) @(negedge clk_i);
        rst_i = 1'b0;
        @(negedge clk_i);
    endtask

    initial begin
        logic [3:0] order;
        line_a5   = {32{8'hA5}};
        line_1234 = {16{16'h1234}};
        line_5a   = {32{8'h5A}};
        line_c3   = {32{8'hC3}};
        ack_man = 1'b0;
        rst_i = 1'b1;
        i_enable_i = 1'b0; d_enable_i = 1'b0; d_write_i = 1'b0;
        i_addr_i = '0; d_addr_i = '0; d_data_i = '0;
        repeat (3) @(negedge clk_i);
        check_zero("reset_held");
        rst_i = 1'b0;
        @(negedge clk_i);
        check_zero("after_release");

        single(1'b0, 1'b0, 32'h0000_0400, '0, line_a5);
        single(1'b1, 1'b1, 32'h0000_0020, line_1234, line_5a);
        checks++;
        if (i_data_o !== line_a5) begin
            errors++;
            $display("FAIL i_data_hold got=%h exp=%h", i_data_o, line_a5);
        end

        // Payload must not follow requester changes during BUSY
        expect_txn(1'b1, 1'b0, 32'h0000_0020, line_c3, line_1234);
        d_addr_i = 32'h0000_0020; d_write_i = 1'b0; d_data_i = line_c3; d_enable_i = 1'b1;
        repeat (3) @(negedge clk_i);
        d_addr_i = 32'h0000_0040; d_enable_i = 1'b0; d_write_i = 1'b1; d_data_i = ~line_c3;
        wait_ack(40);
        repeat (3) @(negedge clk_i);
        check_bit("no_reissue_after_drop", mem_enable_o, 1'b0);

        // Spurious memory ack in IDLE
        ack_man = 1'b1;
        @(negedge clk_i);
        ack_man = 1'b0;
        repeat (2) @(negedge clk_i);
        check_bit("spurious_no_enable", mem_enable_o, 1'b0);
        single(1'b0, 1'b0, 32'h0000_0800, '0, line_5a);

        // Single tie: D first, then I
        pulse_reset();
        d_data_i = '0; d_write_i = 1'b0;
        expect_txn(1'b1, 1'b0, 32'h0000_0100, '0, line_1234);
        expect_txn(1'b0, 1'b0, 32'h0000_0200, '0, line_a5);
        d_addr_i = 32'h0000_0100; i_addr_i = 32'h0000_0200;
        d_enable_i = 1'b1; i_enable_i = 1'b1;
        wait_ack(40);
        d_enable_i = 1'b0;
        wait_ack(40);
        i_enable_i = 1'b0;
        repeat (2) @(negedge clk_i);

        // Continuous contention, four grants
        pulse_reset();
`ifdef ARB_ROUND_ROBIN_EN
        order = 4'b0101;
`else
        order = 4'b1111;
`endif
        for (int k = 0; k < 4; k++) begin
            expect_txn(order[k], 1'b0, order[k] ? 32'h0000_0100 : 32'h0000_0200, '0,
                       {8{k[31:0] + 32'h1111_0000}});
        end
        d_enable_i = 1'b1; i_enable_i = 1'b1;
        for (int k = 0; k < 4; k++) wait_ack(40);
        d_enable_i = 1'b0; i_enable_i = 1'b0;
        repeat (3) @(negedge clk_i);
        check_bit("contention_idle", mem_enable_o, 1'b0);

        // Reset during BUSY, then a late memory ack
        resp_en = 1'b0;
        begin
            mreq_t m;
            m.addr = 32'h0000_0300; m.wr = 1'b0; m.data = '0;
            mem_exp.push_back(m);
        end
        i_addr_i = 32'h0000_0300; i_enable_i = 1'b1;
        repeat (3) @(negedge clk_i);
        rst_i = 1'b1;
        #1;
        check_zero("reset_mid_busy");
        i_enable_i = 1'b0;
        repeat (2) @(negedge clk_i);
        rst_i = 1'b0;
        @(negedge clk_i);
        ack_man = 1'b1;
        @(negedge clk_i);
        ack_man = 1'b0;
        repeat (3) @(negedge clk_i);
        check_bit("late_ack_no_enable", mem_enable_o, 1'b0);
        check_bit("late_ack_no_iack", i_ack_o, 1'b0);
        resp_en = 1'b1;

        checks++;
        if (mem_exp.size() != 0 || ack_exp.size() != 0) begin
            errors++;
            $display("FAIL leftover mem_exp=%0d ack_exp=%0d exp=0", mem_exp.size(), ack_exp.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not complete");
        $fatal(1);
    end
endmodule
